// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output path: DSP width, geometry,
// FSM states and the requantisation helper reused by the pooling stages.
package conv_pkg;

  localparam int unsigned OUTPUT_DSP_WIDTH = 48;
  localparam int unsigned ACC_W            = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int unsigned out_size(input int unsigned fm, input int unsigned k,
                                           input int unsigned pad, input int unsigned stride);
    return ((fm - k + 2 * pad) / stride) + 1;
  endfunction

  // Round half up, arithmetic shift, optional ReLU, saturate to out_w signed bits.
  function automatic logic signed [ACC_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc,
                                                        input int unsigned shift,
                                                        input int unsigned out_w,
                                                        input logic relu);
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    rnd = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (relu && rnd[ACC_W-1]) begin
      return '0;
    end
    if (rnd > hi) begin
      return hi;
    end
    if (rnd < lo) begin
      return lo;
    end
    return rnd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word; a push into an empty FIFO
// appears on the output the next cycle. Capacity is exactly DEPTH entries.
module sync_fifo #(
  parameter int unsigned  WIDTH = 8,
  parameter int unsigned  DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             pop, push_ok;

  always_comb begin
    pop      = valid_q & i_ready;
    push_ok  = i_push & ((count_q != CNT_W'(DEPTH)) | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    // Refill the head from storage, or bypass the incoming word when nothing sits behind it.
    if (pop || !valid_q) begin
      if ((count_q - CNT_W'(pop)) == '0) begin
        if (push_ok) data_d = i_data;
      end else begin
        data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;

endmodule

// File: rtl/conv_out_postproc.sv
// Convolution output post-processing: bias add, round-shift, ReLU, saturation,
// coordinate tagging and buffering toward the output-feature-map writer.
module conv_out_postproc
  import conv_pkg::*;
#(
  parameter int unsigned  FM_SIZE     = 5,
  parameter int unsigned  KERNEL_SIZE = 3,
  parameter int unsigned  PADDING     = 0,
  parameter int unsigned  STRIDE      = 1,
  parameter int unsigned  IN_WIDTH    = conv_pkg::OUTPUT_DSP_WIDTH,
  parameter int unsigned  BIAS_WIDTH  = 32,
  parameter int unsigned  OUT_WIDTH   = 16,
  parameter int unsigned  SHIFT       = 4,
  parameter bit           RELU        = 1'b1,
  parameter int unsigned  FIFO_DEPTH  = 16,
  localparam int unsigned OUT_SIZE    = out_size(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE),
  localparam int unsigned RC_W        = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic signed [BIAS_WIDTH-1:0] i_bias,
  input  logic                         i_en,
  input  logic signed [IN_WIDTH-1:0]   i_P,
  output logic signed [OUT_WIDTH-1:0]  o_data,
  output logic        [RC_W-1:0]       o_row,
  output logic        [RC_W-1:0]       o_col,
  output logic                         o_last,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_overflow
);

  localparam int unsigned TOTAL  = OUT_SIZE * OUT_SIZE;
  localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
  localparam int unsigned S1_W   = IN_WIDTH + 1;
  localparam int unsigned FIFO_W = OUT_WIDTH + 2 * RC_W + 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

  state_e                        state_q, state_d;
  logic signed [BIAS_WIDTH-1:0]  bias_q, bias_d;
  logic [RC_W-1:0]               row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          ovf_q, ovf_d;
  logic                          busy_q, done_q;
  logic                          accept_c, last_c;

  logic                          s1_vld_q, s1_last_q;
  logic signed [S1_W-1:0]        s1_q;
  logic [RC_W-1:0]               s1_row_q, s1_col_q;
  logic                          s2_vld_q, s2_last_q;
  logic signed [OUT_WIDTH-1:0]   s2_q;
  logic [RC_W-1:0]               s2_row_q, s2_col_q;

  logic                          fifo_full, fifo_empty, fifo_valid;
  logic [FCNT_W-1:0]             fifo_count;
  logic [FIFO_W-1:0]             fifo_dout;
  logic                          pop_c, drop_c, drained_c;

  assign last_c    = (cnt_q == CNT_W'(TOTAL - 1));
  assign pop_c     = fifo_valid & i_ready;
  assign drop_c    = s2_vld_q & fifo_full & ~pop_c;
  // FIFO counts as drained when empty or when its final word leaves this cycle.
  assign drained_c = fifo_empty | ((fifo_count == FCNT_W'(1)) & pop_c);

  always_comb begin
    state_d  = state_q;
    bias_d   = bias_q;
    row_d    = row_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          bias_d  = i_bias;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (i_en) begin
          accept_c = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (col_q == RC_W'(OUT_SIZE - 1)) begin
            col_d = '0;
            row_d = row_q + RC_W'(1);
          end else begin
            col_d = col_q + RC_W'(1);
          end
          if (last_c) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_vld_q && !s2_vld_q && drained_c) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (drop_c) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      bias_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bias_q  <= bias_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Stage 1 adds the bias; stage 2 requantises.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      s1_row_q  <= '0;
      s1_col_q  <= '0;
      s1_last_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_q      <= '0;
      s2_row_q  <= '0;
      s2_col_q  <= '0;
      s2_last_q <= 1'b0;
    end else begin
      s1_vld_q  <= accept_c;
      s1_q      <= S1_W'(i_P) + S1_W'(bias_q);
      s1_row_q  <= row_q;
      s1_col_q  <= col_q;
      s1_last_q <= last_c;
      s2_vld_q  <= s1_vld_q;
      s2_q      <= OUT_WIDTH'(round_sat(ACC_W'(s1_q), SHIFT, OUT_WIDTH, RELU));
      s2_row_q  <= s1_row_q;
      s2_col_q  <= s1_col_q;
      s2_last_q <= s1_last_q;
    end
  end

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (s2_vld_q),
    .i_data  ({s2_q, s2_row_q, s2_col_q, s2_last_q}),
    .i_ready (i_ready),
    .o_data  (fifo_dout),
    .o_valid (fifo_valid),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign {o_data, o_row, o_col, o_last} = fifo_dout;
  assign o_valid    = fifo_valid;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_conv_out_postproc.sv
// Bench for conv_out_postproc: instance A uses defaults (3x3 map, ReLU on),
// instance B is a 6x6 map with ReLU off for negative, saturation and overflow cases.
module tb_conv_out_postproc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               start [2];
  logic               en    [2];
  logic               ready [2];
  logic signed [31:0] bias  [2];
  logic signed [47:0] p     [2];
  logic signed [15:0] data  [2];
  logic               valid [2];
  logic               last  [2];
  logic               busy  [2];
  logic               done  [2];
  logic               ovf   [2];
  logic [1:0]         row_a, col_a;
  logic [2:0]         row_b, col_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv_out_postproc u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_bias(bias[0]), .i_en(en[0]), .i_P(p[0]),
    .o_data(data[0]), .o_row(row_a), .o_col(col_a), .o_last(last[0]), .o_valid(valid[0]),
    .i_ready(ready[0]), .o_busy(busy[0]), .o_done(done[0]), .o_overflow(ovf[0])
  );

  conv_out_postproc #(.FM_SIZE(7), .KERNEL_SIZE(2), .RELU(1'b0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_bias(bias[1]), .i_en(en[1]), .i_P(p[1]),
    .o_data(data[1]), .o_row(row_b), .o_col(col_b), .o_last(last[1]), .o_valid(valid[1]),
    .i_ready(ready[1]), .o_busy(busy[1]), .o_done(done[1]), .o_overflow(ovf[1])
  );

  typedef struct {
    int     inst;
    int     bias;
    longint p;
    int     expv;
  } vec_t;
  vec_t vecs [16];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; en[k] = 1'b0; ready[k] = 1'b1; bias[k] = '0; p[k] = '0;
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    int  k;
    bit  got;
    k = vecs[idx].inst;
    do_reset();
    bias[k] = vecs[idx].bias;
    start[k] = 1'b1; tick(); start[k] = 1'b0;
    p[k] = 48'(vecs[idx].p);
    en[k] = 1'b1; tick(); en[k] = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (valid[k]) got = 1'b1;
    end
    check($sformatf("vec%0d_valid", idx), 64'(got), 1);
    if (got) check($sformatf("vec%0d_data", idx), data[k], vecs[idx].expv);
  endtask

  // Full 3x3 map on instance A; output n carries data n by driving i_P = 16*n.
  task automatic run_map_a(input int gap, input bit mid_start);
    int n, dones, en_cyc, first_v, last_pop;
    n = 0; dones = 0; en_cyc = -1; first_v = -1; last_pop = -100;
    ready[0] = 1'b1; bias[0] = 0;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          en[0] = 1'b1; p[0] = 48'(i * 16);
          if (mid_start && i == 4) begin start[0] = 1'b1; bias[0] = 160; end
          if (i == 0) en_cyc = cyc;
          tick();
          en[0] = 1'b0; start[0] = 1'b0;
          for (int g = 0; g < gap; g++) tick();
        end
      end
      begin
        for (int c = 0; c < 80; c++) begin
          tick();
          if (valid[0]) begin
            if (first_v < 0) first_v = cyc;
            check($sformatf("map_data%0d", n), data[0], n);
            check($sformatf("map_row%0d", n), 64'(row_a), n / 3);
            check($sformatf("map_col%0d", n), 64'(col_a), n % 3);
            check($sformatf("map_last%0d", n), 64'(last[0]), (n == 8) ? 1 : 0);
            n++;
            last_pop = cyc;
          end
          if (done[0]) begin
            dones++;
            check("map_done_after_pop", cyc - last_pop, 1);
            check("map_outputs_at_done", n, 9);
          end
        end
      end
    join
    check("map_first_latency", first_v - en_cyc, 3);
    check("map_outputs", n, 9);
    check("map_done_pulses", dones, 1);
    check("map_busy_end", 64'(busy[0]), 0);
  endtask

  initial begin
    int n, dones, seen;
    vecs[0]  = '{0, 4, 100, 7};
    vecs[1]  = '{0, 0, -50, 0};
    vecs[2]  = '{1, 0, -50, -3};
    vecs[3]  = '{0, 0, 1073741824, 32767};
    vecs[4]  = '{1, 0, -1073741824, -32768};
    vecs[5]  = '{1, 0, 23, 1};
    vecs[6]  = '{1, 0, 8, 1};
    vecs[7]  = '{1, 0, 7, 0};
    vecs[8]  = '{1, 0, -24, -1};
    vecs[9]  = '{1, 0, -9, -1};
    vecs[10] = '{1, 0, 524280, 32767};
    vecs[11] = '{1, 0, 524264, 32767};
    vecs[12] = '{1, 0, -524296, -32768};
    vecs[13] = '{1, 0, -524313, -32768};
    vecs[14] = '{1, 32'sh8000_0000, 64'sd1099511627776, 32767};
    vecs[15] = '{1, -100, 0, -6};

    do_reset();
    check("rst_valid", 64'(valid[0]), 0);
    check("rst_done", 64'(done[0]), 0);
    check("rst_overflow", 64'(ovf[0]), 0);
    check("rst_busy", 64'(busy[0]), 0);
    check("rst_last", 64'(last[0]), 0);
    check("rst_data", data[0], 0);
    check("rst_row", 64'(row_a), 0);
    check("rst_col", 64'(col_a), 0);

    for (int i = 0; i < 16; i++) run_vec(i);

    do_reset();
    run_map_a(0, 1'b0);
    run_map_a(2, 1'b0);

    // Reset after four accepted results with the consumer stalled.
    do_reset();
    ready[0] = 1'b0;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en[0] = 1'b1; p[0] = 48'(i * 16); tick();
    end
    en[0] = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_valid", 64'(valid[0]), 1);
    check("pre_rst_busy", 64'(busy[0]), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    ready[0] = 1'b1;
    check("mid_rst_valid", 64'(valid[0]), 0);
    check("mid_rst_busy", 64'(busy[0]), 0);
    check("mid_rst_data", data[0], 0);
    seen = 0;
    en[0] = 1'b1; p[0] = 48'(160);
    for (int c = 0; c < 15; c++) begin
      tick();
      if (c == 5) en[0] = 1'b0;
      if (valid[0] || done[0]) seen++;
    end
    check("idle_en_ignored", seen, 0);
    check("idle_busy", 64'(busy[0]), 0);

    run_map_a(0, 1'b1);

    // Overflow: 36 results into a 16-entry FIFO with the consumer stalled.
    do_reset();
    ready[1] = 1'b0;
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    for (int i = 0; i < 36; i++) begin
      en[1] = 1'b1; p[1] = 48'(i * 16); tick();
    end
    en[1] = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("ovf_flag", 64'(ovf[1]), 1);
    check("ovf_valid_held", 64'(valid[1]), 1);
    check("ovf_head_data", data[1], 0);
    check("ovf_busy", 64'(busy[1]), 1);
    ready[1] = 1'b1;
    n = 0; dones = 0;
    for (int c = 0; c < 60; c++) begin
      if (valid[1]) begin
        check($sformatf("ovf_data%0d", n), data[1], n);
        check($sformatf("ovf_row%0d", n), 64'(row_b), n / 6);
        check($sformatf("ovf_col%0d", n), 64'(col_b), n % 6);
        n++;
      end
      tick();
      if (done[1]) dones++;
    end
    check("ovf_outputs", n, 16);
    check("ovf_done_pulses", dones, 1);
    check("ovf_sticky", 64'(ovf[1]), 1);
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    check("ovf_cleared_on_start", 64'(ovf[1]), 0);
    check("ovf_restart_busy", 64'(busy[1]), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
